// File: rtl/prox_i2c_reader.sv
// APDS-9901 proximity poller: writes the register init table once, then reads
// PDATAL/PDATAH over I2C every poll interval and publishes {PDATAH, PDATAL}.
module prox_i2c_reader #(
    parameter int         CLK_DIV   = 30,
    parameter int         POLL_CYC  = 120000,
    parameter int         VALID_CYC = 8,
    parameter logic [6:0] DEV_ADDR  = 7'h39
) (
    input  logic        clk,
    input  logic        rst_n,
    output wire         i2c_scl,
    inout  wire         i2c_sda,
    output logic [15:0] prox_dat,
    output logic        dat_valid,
    output logic        ack_err
);
    localparam int DIV_W   = $clog2(CLK_DIV + 1);
    localparam int GAP_CYC = 4 * CLK_DIV;
    localparam int POLL_W  = $clog2(POLL_CYC + 1);
    localparam int GAP_W   = $clog2(GAP_CYC + 1);
    localparam int WAIT_W0 = (POLL_W > 17) ? POLL_W : 17;
    localparam int WAIT_W  = (GAP_W > WAIT_W0) ? GAP_W : WAIT_W0;
    localparam int VAL_W   = $clog2(VALID_CYC + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [WAIT_W-1:0] POLL_LAST = WAIT_W'(POLL_CYC - 1);
    localparam logic [WAIT_W-1:0] GAP_LAST  = WAIT_W'(GAP_CYC - 1);
    localparam logic [VAL_W-1:0]  VAL_LAST  = VAL_W'(VALID_CYC - 1);
    localparam logic [2:0]        INIT_LAST = 3'd5;

    typedef enum logic [3:0] {
        ST_IDLE, ST_START, ST_TX_BIT, ST_RX_ACK, ST_RSTART,
        ST_RX_BIT, ST_TX_ACK, ST_STOP, ST_WAIT
    } state_e;

    typedef enum logic {PH_INIT, PH_READ} phase_e;

    state_e            state_q, state_d;
    phase_e            phase_q, phase_d;
    logic [2:0]        init_idx_q, init_idx_d;
    logic [2:0]        byte_cnt_q, byte_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [1:0]        qtr_q, qtr_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              wait_poll_q, wait_poll_d;
    logic              nack_q, nack_d;
    logic              err_pend_q, err_pend_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic [7:0]        byte_lo_q, byte_lo_d;
    logic [15:0]       prox_dat_q, prox_dat_d;
    logic              dat_valid_q, dat_valid_d;
    logic [VAL_W-1:0]  valid_cnt_q, valid_cnt_d;
    logic              ack_err_q, ack_err_d;
    logic              scl_low_q, scl_low_d;
    logic              sda_low_q, sda_low_d;
    logic              sda_meta_q, sda_sync_q;

    logic       tick;
    logic       last_qtr;
    logic [7:0] init_reg;
    logic [7:0] init_data;
    logic [7:0] tx_byte;

    assign tick     = (div_cnt_q == DIV_LAST);
    assign last_qtr = tick && (qtr_q == 2'd3);

    always_comb begin
        init_reg  = 8'h00;
        init_data = 8'h00;
        case (init_idx_q)
            3'd0: begin init_reg = 8'h00; init_data = 8'h00; end
            3'd1: begin init_reg = 8'h02; init_data = 8'hFF; end
            3'd2: begin init_reg = 8'h03; init_data = 8'hFF; end
            3'd3: begin init_reg = 8'h0E; init_data = 8'h08; end
            3'd4: begin init_reg = 8'h0F; init_data = 8'h20; end
            3'd5: begin init_reg = 8'h00; init_data = 8'h05; end
            default: ;
        endcase
    end

    // Write bytes 0..2; a read uses byte 2 as the address after the repeated START.
    always_comb begin
        tx_byte = {DEV_ADDR, 1'b0};
        case (byte_cnt_q)
            3'd1: tx_byte = (phase_q == PH_READ) ? 8'hB8 : (8'h80 | init_reg);
            3'd2: tx_byte = (phase_q == PH_READ) ? {DEV_ADDR, 1'b1} : init_data;
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        init_idx_d  = init_idx_q;
        byte_cnt_d  = byte_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        qtr_d       = qtr_q;
        div_cnt_d   = tick ? '0 : div_cnt_q + DIV_W'(1);
        wait_cnt_d  = wait_cnt_q;
        wait_poll_d = wait_poll_q;
        nack_d      = nack_q;
        err_pend_d  = err_pend_q;
        rx_shift_d  = rx_shift_q;
        byte_lo_d   = byte_lo_q;
        prox_dat_d  = prox_dat_q;
        dat_valid_d = dat_valid_q;
        valid_cnt_d = valid_cnt_q;
        ack_err_d   = ack_err_q;
        scl_low_d   = 1'b0;
        sda_low_d   = 1'b0;

        if (dat_valid_q) begin
            if (valid_cnt_q == '0) dat_valid_d = 1'b0;
            else                   valid_cnt_d = valid_cnt_q - VAL_W'(1);
        end

        if (tick && state_q != ST_IDLE && state_q != ST_WAIT) qtr_d = qtr_q + 2'd1;

        case (state_q)
            ST_IDLE: begin
                if (tick) state_d = ST_START;
            end
            ST_START: begin
                scl_low_d = (qtr_q == 2'd3);
                sda_low_d = 1'b1;
                if (last_qtr) begin
                    state_d    = ST_TX_BIT;
                    bit_cnt_d  = 3'd7;
                    byte_cnt_d = 3'd0;
                end
            end
            ST_TX_BIT: begin
                scl_low_d = (qtr_q == 2'd0) || (qtr_q == 2'd3);
                sda_low_d = ~tx_byte[bit_cnt_q];
                if (last_qtr) begin
                    if (bit_cnt_q == 3'd0) state_d = ST_RX_ACK;
                    else                   bit_cnt_d = bit_cnt_q - 3'd1;
                end
            end
            ST_RX_ACK: begin
                scl_low_d = (qtr_q == 2'd0) || (qtr_q == 2'd3);
                if (tick && qtr_q == 2'd2) nack_d = sda_sync_q;
                if (last_qtr) begin
                    bit_cnt_d  = 3'd7;
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    if (nack_q) begin
                        state_d    = ST_STOP;
                        err_pend_d = 1'b1;
                    end else if (phase_q == PH_READ) begin
                        case (byte_cnt_q)
                            3'd0:    state_d = ST_TX_BIT;
                            3'd1:    state_d = ST_RSTART;
                            default: state_d = ST_RX_BIT;
                        endcase
                    end else begin
                        state_d = (byte_cnt_q == 3'd2) ? ST_STOP : ST_TX_BIT;
                    end
                end
            end
            ST_RSTART: begin
                scl_low_d = (qtr_q == 2'd0) || (qtr_q == 2'd3);
                sda_low_d = (qtr_q >= 2'd2);
                if (last_qtr) begin
                    state_d   = ST_TX_BIT;
                    bit_cnt_d = 3'd7;
                end
            end
            ST_RX_BIT: begin
                scl_low_d = (qtr_q == 2'd0) || (qtr_q == 2'd3);
                if (tick && qtr_q == 2'd2) rx_shift_d = {rx_shift_q[6:0], sda_sync_q};
                if (last_qtr) begin
                    if (bit_cnt_q == 3'd0) state_d = ST_TX_ACK;
                    else                   bit_cnt_d = bit_cnt_q - 3'd1;
                end
            end
            ST_TX_ACK: begin
                // PDATAL is ACKed so the sensor continues; PDATAH is NACKed to end the burst.
                scl_low_d = (qtr_q == 2'd0) || (qtr_q == 2'd3);
                sda_low_d = (byte_cnt_q == 3'd3);
                if (last_qtr) begin
                    if (byte_cnt_q == 3'd3) begin
                        byte_lo_d  = rx_shift_q;
                        byte_cnt_d = 3'd4;
                        bit_cnt_d  = 3'd7;
                        state_d    = ST_RX_BIT;
                    end else begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                scl_low_d = (qtr_q == 2'd0);
                sda_low_d = (qtr_q <= 2'd1);
                if (last_qtr) begin
                    state_d     = ST_WAIT;
                    wait_cnt_d  = '0;
                    wait_poll_d = 1'b1;
                    err_pend_d  = 1'b0;
                    nack_d      = 1'b0;
                    if (err_pend_q) begin
                        ack_err_d = 1'b1;
                        if (phase_q == PH_INIT) init_idx_d = 3'd0;
                    end else begin
                        ack_err_d = 1'b0;
                        if (phase_q == PH_READ) begin
                            prox_dat_d  = {rx_shift_q, byte_lo_q};
                            dat_valid_d = 1'b1;
                            valid_cnt_d = VAL_LAST;
                        end else begin
                            wait_poll_d = 1'b0;
                            if (init_idx_q == INIT_LAST) begin
                                phase_d    = PH_READ;
                                init_idx_d = 3'd0;
                            end else begin
                                init_idx_d = init_idx_q + 3'd1;
                            end
                        end
                    end
                end
            end
            ST_WAIT: begin
                // Divider is held so the next START begins on a fresh tick boundary.
                div_cnt_d = '0;
                qtr_d     = 2'd0;
                if (wait_cnt_q == (wait_poll_q ? POLL_LAST : GAP_LAST)) begin
                    wait_cnt_d = '0;
                    state_d    = ST_START;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH_INIT;
            init_idx_q  <= 3'd0;
            byte_cnt_q  <= 3'd0;
            bit_cnt_q   <= 3'd7;
            qtr_q       <= 2'd0;
            div_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            wait_poll_q <= 1'b0;
            nack_q      <= 1'b0;
            err_pend_q  <= 1'b0;
            rx_shift_q  <= 8'h00;
            byte_lo_q   <= 8'h00;
            prox_dat_q  <= 16'h0000;
            dat_valid_q <= 1'b0;
            valid_cnt_q <= '0;
            ack_err_q   <= 1'b0;
            scl_low_q   <= 1'b0;
            sda_low_q   <= 1'b0;
            sda_meta_q  <= 1'b1;
            sda_sync_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            init_idx_q  <= init_idx_d;
            byte_cnt_q  <= byte_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            qtr_q       <= qtr_d;
            div_cnt_q   <= div_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            wait_poll_q <= wait_poll_d;
            nack_q      <= nack_d;
            err_pend_q  <= err_pend_d;
            rx_shift_q  <= rx_shift_d;
            byte_lo_q   <= byte_lo_d;
            prox_dat_q  <= prox_dat_d;
            dat_valid_q <= dat_valid_d;
            valid_cnt_q <= valid_cnt_d;
            ack_err_q   <= ack_err_d;
            scl_low_q   <= scl_low_d;
            sda_low_q   <= sda_low_d;
            sda_meta_q  <= i2c_sda;
            sda_sync_q  <= sda_meta_q;
        end
    end

    assign i2c_scl   = scl_low_q ? 1'b0 : 1'bz;
    assign i2c_sda   = sda_low_q ? 1'b0 : 1'bz;
    assign prox_dat  = prox_dat_q;
    assign dat_valid = dat_valid_q;
    assign ack_err   = ack_err_q;

endmodule
